// File: rtl/xif_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pa_xif_mem_arb (package)
// Description : Shared types for the XIF memory arbiter: FSM state encoding
//               and the pending-transaction entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package pa_xif_mem_arb;

  localparam int unsigned NUM_REQ_DEF    = 2;
  localparam int unsigned X_ID_WIDTH_DEF = 4;

  // Arbiter FSM: IDLE picks a requester, BUSY presents it downstream
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // One outstanding transaction: who issued it and with which id
  typedef struct packed {
    logic [$clog2(NUM_REQ_DEF)-1:0] owner;
    logic [X_ID_WIDTH_DEF-1:0]      id;
  } pend_entry_t;

endpackage
`default_nettype wire

// File: rtl/xif_mem_arbiter_pend_fifo.sv
`default_nettype none
// ============================================================================
// Module      : xif_pend_fifo
// Description : Small synchronous FIFO tracking in-order pending memory
//               transactions (owner + id). Pointers wrap modulo DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
module xif_pend_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (count_q == (PW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign head_o    = mem_q[rd_ptr_q];
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;

  // Storage, pointers and occupancy; simultaneous push/pop leaves count unchanged
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/xif_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : xif_mem_arbiter
// Description : Round-robin arbiter sharing one XIF memory request port among
//               NUM_REQ requesters, with in-order result routing back to the
//               issuing requester via a pending-transaction FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module xif_mem_arbiter
  import pa_xif_mem_arb::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_MEM_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned PEND_DEPTH  = 4
) (
  input  logic                             ck,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*X_ID_WIDTH-1:0]    req_id,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*X_MEM_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*3-1:0]             req_size,
  input  logic [NUM_REQ*X_MEM_WIDTH/8-1:0] req_be,
  output logic                             mem_valid,
  input  logic                             mem_ready,
  output logic [X_ID_WIDTH-1:0]            mem_id,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [X_MEM_WIDTH-1:0]           mem_wdata,
  output logic                             mem_we,
  output logic [2:0]                       mem_size,
  output logic [X_MEM_WIDTH/8-1:0]         mem_be,
  input  logic                             mem_result_valid,
  input  logic [X_ID_WIDTH-1:0]            mem_result_id,
  input  logic [X_MEM_WIDTH-1:0]           mem_result_rdata,
  input  logic                             mem_result_err,
  output logic [NUM_REQ-1:0]               res_valid,
  output logic [X_MEM_WIDTH-1:0]           res_rdata,
  output logic                             res_err,
  output logic                             err_unexpected,
  output logic                             err_id_mismatch
);

  localparam int unsigned OW = $clog2(NUM_REQ);
  localparam int unsigned EW = OW + X_ID_WIDTH;
  localparam int unsigned BW = X_MEM_WIDTH / 8;

  arb_state_e        state_q, state_d;
  logic [OW-1:0]     grant_q, grant_d;
  logic [OW-1:0]     last_grant_q, last_grant_d;
  logic              err_unexp_q, err_unexp_d;
  logic              err_idm_q, err_idm_d;
  logic              w_hs;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [EW-1:0]     w_head;
  logic [OW-1:0]     w_head_owner;
  logic [X_ID_WIDTH-1:0] w_head_id;
  logic [OW-1:0]     w_pick;
  logic              w_found;

  assign w_hs         = (state_q == BUSY) && mem_ready;
  assign w_pop        = mem_result_valid && !w_empty;
  assign w_head_owner = w_head[EW-1:X_ID_WIDTH];
  assign w_head_id    = w_head[X_ID_WIDTH-1:0];

  xif_pend_fifo #(
    .WIDTH (EW),
    .DEPTH (PEND_DEPTH)
  ) u_fifo (
    .ck      (ck),
    .rst_n   (rst_n),
    .push_i  (w_hs),
    .data_i  ({grant_q, req_id[int'(grant_q)*X_ID_WIDTH +: X_ID_WIDTH]}),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

  // State, grant and sticky error registers
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= OW'(NUM_REQ - 1);
      err_unexp_q  <= 1'b0;
      err_idm_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      err_unexp_q  <= err_unexp_d;
      err_idm_q    <= err_idm_d;
    end
  end

  // Round-robin pick: first valid requester at or after last_grant+1
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      if (!w_found && req_valid[(int'(last_grant_q) + k) % int'(NUM_REQ)]) begin
        w_found = 1'b1;
        w_pick  = OW'((int'(last_grant_q) + k) % int'(NUM_REQ));
      end
    end
  end

  // Next state: full FIFO (registered count) blocks new grants
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    err_unexp_d  = err_unexp_q || (mem_result_valid && w_empty);
    err_idm_d    = err_idm_q || (w_pop && (w_head_id != mem_result_id));
    case (state_q)
      IDLE: begin
        if (w_found && !w_full) begin
          grant_d = w_pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (w_hs) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: payload mux only while BUSY, results routed to head owner
  always_comb begin
    mem_valid = 1'b0;
    req_ready = '0;
    mem_id    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_size  = '0;
    mem_be    = '0;
    if (state_q == BUSY) begin
      mem_valid          = 1'b1;
      req_ready[grant_q] = mem_ready;
      mem_id             = req_id[int'(grant_q)*X_ID_WIDTH +: X_ID_WIDTH];
      mem_addr           = req_addr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_wdata          = req_wdata[int'(grant_q)*X_MEM_WIDTH +: X_MEM_WIDTH];
      mem_we             = req_we[grant_q];
      mem_size           = req_size[int'(grant_q)*3 +: 3];
      mem_be             = req_be[int'(grant_q)*BW +: BW];
    end
    res_valid = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      res_valid[i] = w_pop && (w_head_owner == OW'(i));
    end
  end

  assign res_rdata       = mem_result_rdata;
  assign res_err         = mem_result_err;
  assign err_unexpected  = err_unexp_q;
  assign err_id_mismatch = err_idm_q;

endmodule
`default_nettype wire

// File: tb/tb_xif_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_xif_mem_arbiter
// Description : Directed self-checking bench for xif_mem_arbiter with a
//               scoreboard of accepted transactions for result routing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xif_mem_arbiter;

  localparam int NR = 2;
  localparam int IW = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic              ck = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_ready, req_we;
  logic [NR*IW-1:0]  req_id;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*3-1:0]   req_size;
  logic [NR*DW/8-1:0] req_be;
  logic              mem_valid, mem_ready, mem_we;
  logic [IW-1:0]     mem_id;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [2:0]        mem_size;
  logic [DW/8-1:0]   mem_be;
  logic              mem_result_valid, mem_result_err;
  logic [IW-1:0]     mem_result_id;
  logic [DW-1:0]     mem_result_rdata;
  logic [NR-1:0]     res_valid;
  logic [DW-1:0]     res_rdata;
  logic              res_err, err_unexpected, err_id_mismatch;

  typedef struct {
    int         owner;
    logic [3:0] id;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 ck = ~ck;

  xif_mem_arbiter #(
    .NUM_REQ(NR), .X_ID_WIDTH(IW), .X_MEM_WIDTH(DW), .ADDR_WIDTH(AW), .PEND_DEPTH(4)
  ) dut (
    .ck(ck), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
    .req_size(req_size), .req_be(req_be),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_id(mem_id),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_size(mem_size), .mem_be(mem_be),
    .mem_result_valid(mem_result_valid), .mem_result_id(mem_result_id),
    .mem_result_rdata(mem_result_rdata), .mem_result_err(mem_result_err),
    .res_valid(res_valid), .res_rdata(res_rdata), .res_err(res_err),
    .err_unexpected(err_unexpected), .err_id_mismatch(err_id_mismatch)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic set_req(input int r, input logic [3:0] id, input logic [31:0] addr);
    req_id[r*IW +: IW]     = id;
    req_addr[r*AW +: AW]   = addr;
    req_wdata[r*DW +: DW]  = addr ^ 32'hA5A5_0000;
    req_we[r]              = (r == 1);
    req_size[r*3 +: 3]     = 3'd2;
    req_be[r*4 +: 4]       = 4'hF;
  endtask

  task automatic accept(input int owner, input logic [3:0] id);
    exp_t e;
    e.owner = owner;
    e.id    = id;
    sb.push_back(e);
  endtask

  // Drive one result and compare routing against the scoreboard head
  task automatic result(input string tag, input logic [3:0] id, input logic [31:0] rdata);
    exp_t e;
    mem_result_valid = 1'b1;
    mem_result_id    = id;
    mem_result_rdata = rdata;
    mem_result_err   = 1'b0;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_res_valid"}, 64'(res_valid), 64'(2'b01 << e.owner));
      check({tag, "_res_rdata"}, 64'(res_rdata), 64'(rdata));
    end else begin
      check({tag, "_res_valid_none"}, 64'(res_valid), 64'(0));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_id = '0; req_addr = '0; req_wdata = '0;
    req_we = '0; req_size = '0; req_be = '0; mem_ready = 1'b0;
    mem_result_valid = 1'b0; mem_result_id = '0; mem_result_rdata = '0; mem_result_err = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    check("rst_mem_valid", 64'(mem_valid), 0);
    check("rst_req_ready", 64'(req_ready), 0);
    check("rst_res_valid", 64'(res_valid), 0);
    check("rst_err_unexp", 64'(err_unexpected), 0);
    check("rst_err_idm", 64'(err_id_mismatch), 0);
    check("rst_mem_addr", 64'(mem_addr), 0);
    rst_n = 1'b1;

    // Both request at once: requester 0 first, then 1
    set_req(0, 4'd1, 32'h10);
    set_req(1, 4'd2, 32'h20);
    req_valid = 2'b11; mem_ready = 1'b1;
    #1;
    check("t1_idle_mv", 64'(mem_valid), 0);
    tick();
    check("t1_g0_mv", 64'(mem_valid), 1);
    check("t1_g0_rdy", 64'(req_ready), 64'(2'b01));
    check("t1_g0_id", 64'(mem_id), 1);
    check("t1_g0_addr", 64'(mem_addr), 64'h10);
    check("t1_g0_wdata", 64'(mem_wdata), 64'hA5A5_0010);
    accept(0, 4'd1);
    tick();
    req_valid = 2'b10;
    #1;
    check("t1_idle2_mv", 64'(mem_valid), 0);
    check("t1_idle2_rdy", 64'(req_ready), 0);
    tick();
    check("t1_g1_rdy", 64'(req_ready), 64'(2'b10));
    check("t1_g1_addr", 64'(mem_addr), 64'h20);
    check("t1_g1_we", 64'(mem_we), 1);
    accept(1, 4'd2);
    tick();
    req_valid = 2'b00;
    #1;
    check("t1_done_mv", 64'(mem_valid), 0);

    // In-order results routed to their owners
    result("r_dead", 4'd1, 32'hDEAD);
    tick();
    result("r_beef", 4'd2, 32'hBEEF);
    tick();
    mem_result_valid = 1'b0;
    #1;
    check("r_no_err_idm", 64'(err_id_mismatch), 0);
    check("r_no_err_unexp", 64'(err_unexpected), 0);

    // Backpressure: grant to requester 1 held for 5 cycles
    mem_ready = 1'b0;
    set_req(1, 4'd3, 32'h100);
    req_valid = 2'b10;
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_mv", 64'(mem_valid), 1);
      check("bp_addr", 64'(mem_addr), 64'h100);
      check("bp_rdy", 64'(req_ready), 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("bp_release_rdy", 64'(req_ready), 64'(2'b10));
    accept(1, 4'd3);
    tick();
    req_valid = 2'b00;
    #1;
    check("bp_done_mv", 64'(mem_valid), 0);

    // Id mismatch routes to head owner; then a result with nothing pending
    result("idm", 4'd7, 32'h1234);
    tick();
    mem_result_valid = 1'b0;
    #1;
    check("idm_flag", 64'(err_id_mismatch), 1);
    check("idm_unexp_clear", 64'(err_unexpected), 0);
    result("unexp", 4'd8, 32'h5678);
    tick();
    mem_result_valid = 1'b0;
    #1;
    check("unexp_flag", 64'(err_unexpected), 1);

    // Fill the pending FIFO with four accepted requests
    mem_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      set_req(0, 4'(k), 32'h200 + 32'(k));
      req_valid = 2'b01;
      tick();
      check("fill_rdy", 64'(req_ready), 64'(2'b01));
      check("fill_id", 64'(mem_id), 64'(k));
      accept(0, 4'(k));
      tick();
    end
    mem_ready = 1'b0;
    set_req(0, 4'd5, 32'h300);
    #1;
    check("full_count", 64'(dut.u_fifo.count_q), 4);
    for (int c = 0; c < 3; c++) begin
      check("full_blocked_mv", 64'(mem_valid), 0);
      tick();
    end
    result("full_pop", 4'd1, 32'h1111);
    check("full_pop_still_blocked", 64'(mem_valid), 0);
    tick();
    mem_result_valid = 1'b0;
    #1;
    check("after_pop_idle_mv", 64'(mem_valid), 0);
    tick();
    check("after_pop_grant_mv", 64'(mem_valid), 1);
    check("after_pop_grant_id", 64'(mem_id), 5);
    result("pop_id2", 4'd2, 32'h2222);
    tick();
    check("pre_pushpop_count", 64'(dut.u_fifo.count_q), 2);
    // Push (handshake of id 5) and pop (id 3) in the same cycle
    mem_ready = 1'b1;
    result("pushpop", 4'd3, 32'h3333);
    check("pushpop_rdy", 64'(req_ready), 64'(2'b01));
    accept(0, 4'd5);
    tick();
    mem_result_valid = 1'b0; req_valid = 2'b00; mem_ready = 1'b0;
    #1;
    check("pushpop_count", 64'(dut.u_fifo.count_q), 2);

    // Reset while BUSY clears everything at once
    set_req(1, 4'd9, 32'h400);
    req_valid = 2'b10;
    tick();
    check("rstbusy_mv_pre", 64'(mem_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstbusy_mv", 64'(mem_valid), 0);
    check("rstbusy_count", 64'(dut.u_fifo.count_q), 0);
    check("rstbusy_err_unexp", 64'(err_unexpected), 0);
    check("rstbusy_err_idm", 64'(err_id_mismatch), 0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    req_valid = 2'b00;
    result("post_rst", 4'd4, 32'h4444);
    tick();
    mem_result_valid = 1'b0;
    #1;
    check("post_rst_unexp", 64'(err_unexpected), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
